// File: rtl/sprite_mover_if.sv
// sprite_mover_if: command/status handshake, sprite-ROM port and pixel-write bus of sprite_mover.
// master = the mover itself, slave = the surrounding key logic, ROM and VGA adapter.
interface sprite_mover_if #(
    parameter int COLOUR_W = 3,
    parameter int ADDR_W   = 7
);
    logic                start;
    logic                left;
    logic                right;
    logic [COLOUR_W-1:0] romData;
    logic [ADDR_W-1:0]   romAddr;
    logic [7:0]          xout;
    logic [6:0]          yout;
    logic [COLOUR_W-1:0] colourOut;
    logic                drawEn;
    logic                ready;
    logic                busy;
    logic                edgeHit;
    logic [7:0]          posX;

    modport master (
        input  start, left, right, romData,
        output romAddr, xout, yout, colourOut, drawEn, ready, busy, edgeHit, posX
    );

    modport slave (
        output start, left, right, romData,
        input  romAddr, xout, yout, colourOut, drawEn, ready, busy, edgeHit, posX
    );
endinterface

// File: rtl/sprite_mover.sv
// sprite_mover: clears the screen, draws a ROM sprite at home, then moves it left/right by erase/step/redraw.
// Optional feature macro SPRITE_TRANSPARENT_EN: DRAW suppresses writes of pixels whose colour equals TRANSPARENT.
module sprite_mover #(
    parameter int SCREEN_W    = 160,
    parameter int SCREEN_H    = 120,
    parameter int SPR_W       = 11,
    parameter int SPR_H       = 10,
    parameter int X_START     = 73,
    parameter int Y_START     = 105,
    parameter int STEP        = 5,
    parameter int HOLD_CYCLES = 4,
    parameter int COLOUR_W    = 3,
    parameter int ADDR_W      = 7,
    parameter logic [COLOUR_W-1:0] TRANSPARENT = COLOUR_W'(5)
) (
    input  logic clk,
    input  logic reset,
    sprite_mover_if.master bus
);

    typedef enum logic [2:0] {IDLE, CLEAR, DRAW, READY, ERASE, HOLD} state_t;

    localparam logic [7:0]        CLR_X_LAST = 8'(SCREEN_W - 1);
    localparam logic [6:0]        CLR_Y_LAST = 7'(SCREEN_H - 1);
    localparam logic [7:0]        SPR_X_LAST = 8'(SPR_W - 1);
    localparam logic [6:0]        SPR_Y_LAST = 7'(SPR_H - 1);
    localparam logic [7:0]        HOME_X     = 8'(X_START);
    localparam logic [6:0]        HOME_Y     = 7'(Y_START);
    localparam logic signed [8:0] POS_MAX    = 9'(SCREEN_W - SPR_W);
    localparam logic signed [8:0] STEP_S     = 9'(STEP);
    localparam logic [15:0]       HOLD_LAST  = 16'(HOLD_CYCLES - 1);

`ifdef SPRITE_TRANSPARENT_EN
    localparam bit KEY_EN = 1'b1;
`else
    localparam bit KEY_EN = 1'b0;
`endif

    state_t              state;
    logic [7:0]          posX;
    logic [7:0]          target;
    logic [7:0]          cntX;
    logic [6:0]          cntY;
    logic [ADDR_W-1:0]   romAddr;
    logic                scanning;
    logic                moved;
    logic [15:0]         holdCnt;
    logic                ready;
    logic                busy;
    logic                edgeHit;
    logic [7:0]          xout;
    logic [6:0]          yout;
    logic                vld_p1;
    logic                colSel_p1;

    logic signed [8:0]   posS;
    logic [7:0]          cmdTarget;
    logic                xWrap;
    logic                scanLast;
    logic                isKey;

    function automatic logic [7:0] clampPos(input logic signed [8:0] t);
        if (t < 0)
            return 8'd0;
        else if (t > POS_MAX)
            return POS_MAX[7:0];
        else
            return t[7:0];
    endfunction

    always_comb begin
        posS = $signed({1'b0, posX});
        if (bus.left)
            cmdTarget = clampPos(posS - STEP_S);
        else
            cmdTarget = clampPos(posS + STEP_S);
    end

    always_comb begin
        xWrap    = 1'b0;
        scanLast = 1'b0;
        if (state == CLEAR) begin
            xWrap    = (cntX == CLR_X_LAST);
            scanLast = xWrap && (cntY == CLR_Y_LAST);
        end else begin
            xWrap    = (cntX == SPR_X_LAST);
            scanLast = xWrap && (cntY == SPR_Y_LAST);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            posX      <= HOME_X;
            target    <= HOME_X;
            cntX      <= 8'd0;
            cntY      <= 7'd0;
            romAddr   <= '0;
            scanning  <= 1'b0;
            moved     <= 1'b0;
            holdCnt   <= 16'd0;
            ready     <= 1'b0;
            busy      <= 1'b0;
            edgeHit   <= 1'b0;
            xout      <= 8'd0;
            yout      <= 7'd0;
            vld_p1    <= 1'b0;
            colSel_p1 <= 1'b0;
        end else begin
            vld_p1    <= 1'b0;
            colSel_p1 <= 1'b0;
            edgeHit   <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state    <= CLEAR;
                        busy     <= 1'b1;
                        scanning <= 1'b1;
                        cntX     <= 8'd0;
                        cntY     <= 7'd0;
                        romAddr  <= '0;
                    end
                end
                CLEAR, DRAW, ERASE: begin
                    if (scanning) begin
                        // Stage 0 -> 1: scan position of cycle k becomes the pixel presented in cycle k+1
                        vld_p1    <= 1'b1;
                        colSel_p1 <= (state == DRAW);
                        if (state == CLEAR) begin
                            xout <= cntX;
                            yout <= cntY;
                        end else begin
                            xout    <= posX + cntX;
                            yout    <= HOME_Y + cntY;
                            romAddr <= romAddr + ADDR_W'(1);
                        end
                        if (xWrap) begin
                            cntX <= 8'd0;
                            cntY <= cntY + 7'd1;
                        end else begin
                            cntX <= cntX + 8'd1;
                        end
                        if (scanLast)
                            scanning <= 1'b0;
                    end else begin
                        // Extra cycle lets the last pixel leave the pipeline before the next pass starts
                        scanning <= 1'b1;
                        cntX     <= 8'd0;
                        cntY     <= 7'd0;
                        romAddr  <= '0;
                        case (state)
                            CLEAR: begin
                                state <= DRAW;
                                posX  <= HOME_X;
                                moved <= 1'b0;
                            end
                            ERASE: begin
                                state <= DRAW;
                                posX  <= target;
                            end
                            default: begin
                                if (moved) begin
                                    state   <= HOLD;
                                    holdCnt <= 16'd0;
                                end else begin
                                    state <= READY;
                                    busy  <= 1'b0;
                                    ready <= 1'b1;
                                end
                            end
                        endcase
                    end
                end
                READY: begin
                    if (bus.left ^ bus.right) begin
                        if (cmdTarget == posX) begin
                            edgeHit <= 1'b1;
                        end else begin
                            target <= cmdTarget;
                            moved  <= 1'b1;
                            state  <= ERASE;
                            ready  <= 1'b0;
                            busy   <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (holdCnt == HOLD_LAST) begin
                        state <= READY;
                        busy  <= 1'b0;
                        ready <= 1'b1;
                    end else begin
                        holdCnt <= holdCnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Stage 1: colour comes straight from the ROM, which answers one cycle after romAddr
    assign isKey         = colSel_p1 && (bus.romData == TRANSPARENT);
    assign bus.colourOut = colSel_p1 ? bus.romData : '0;
    assign bus.drawEn    = vld_p1 && !(KEY_EN && isKey);
    assign bus.xout      = xout;
    assign bus.yout      = yout;
    assign bus.romAddr   = romAddr;
    assign bus.ready     = ready;
    assign bus.busy      = busy;
    assign bus.edgeHit   = edgeHit;
    assign bus.posX      = posX;

endmodule

// File: tb/tb_sprite_mover.sv
// tb_sprite_mover: random left/right command stream against a pixel-list reference model of sprite_mover.
module tb_sprite_mover;

    localparam int SW        = 160;
    localparam int SH        = 120;
    localparam int SPW       = 11;
    localparam int SPH       = 10;
    localparam int XS        = 73;
    localparam int YS        = 105;
    localparam int STEP      = 5;
    localparam int HOLDC     = 4;
    localparam int NSPR      = SPW * SPH;
    localparam int POS_MAX   = SW - SPW;
    localparam int MOVE_LOW  = 2 * (NSPR + 1) + HOLDC;
    localparam int KEY       = 5;
`ifdef SPRITE_TRANSPARENT_EN
    localparam bit KEY_EN = 1'b1;
`else
    localparam bit KEY_EN = 1'b0;
`endif

    typedef struct {
        int x;
        int y;
        int c;
        int cyc;
    } wr_t;

    logic clk;
    logic reset;
    sprite_mover_if #(.COLOUR_W(3), .ADDR_W(7)) bus ();

    sprite_mover dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [2:0] rom [0:127];
    wr_t        wq[$];
    int         cyc = 0;
    int         readyLow = 0;
    int         edgeCnt = 0;
    int         busyBad = 0;
    bit         chkBusy = 0;
    int         nChecks = 0;
    int         nErrors = 0;
    int         modelPos;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        bus.romData <= rom[bus.romAddr];
    end

    always @(negedge clk) begin
        if (bus.drawEn === 1'b1)
            wq.push_back('{x: int'(bus.xout), y: int'(bus.yout), c: int'(bus.colourOut), cyc: cyc});
        if (bus.edgeHit === 1'b1)
            edgeCnt++;
        if (bus.ready !== 1'b1)
            readyLow++;
        if (chkBusy && (bus.busy === bus.ready))
            busyBad++;
    end

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint pack(input longint off, input longint x, input longint y, input longint c);
        return (off << 20) | (x << 12) | (y << 4) | c;
    endfunction

    // Expected pixel list of one erase (optional) plus draw, each write tagged with its cycle offset
    task automatic checkMove(input string tag, input int base, input int c0, input int offs0,
                             input int oldPos, input int newPos, input bit doErase);
        longint exp[$];
        int     drawOff;
        int     got;
        wr_t    w;
        drawOff = offs0;
        if (doErase) begin
            for (int i = 0; i < NSPR; i++)
                exp.push_back(pack(offs0 + i, oldPos + i % SPW, YS + i / SPW, 0));
            drawOff = offs0 + NSPR + 1;
        end
        for (int i = 0; i < NSPR; i++)
            if (!(KEY_EN && int'(rom[i]) == KEY))
                exp.push_back(pack(drawOff + i, newPos + i % SPW, YS + i / SPW, int'(rom[i])));
        got = wq.size() - base;
        checkVal({tag, " write count"}, got, exp.size());
        for (int i = 0; i < exp.size() && i < got; i++) begin
            w = wq[base + i];
            checkVal({tag, " pixel"}, pack(w.cyc - c0, w.x, w.y, w.c), exp[i]);
        end
    endtask

    task automatic doCmd(input bit l, input bit r);
        int base, c0, rl0, e0, bb0, tgt, n;
        bit act;
        base = wq.size();
        c0   = cyc;
        rl0  = readyLow;
        e0   = edgeCnt;
        bb0  = busyBad;
        act  = l ^ r;
        tgt  = l ? modelPos - STEP : modelPos + STEP;
        if (tgt < 0) tgt = 0;
        if (tgt > POS_MAX) tgt = POS_MAX;
        bus.left  = l;
        bus.right = r;
        @(negedge clk);
        bus.left  = 1'b0;
        bus.right = 1'b0;
        if (!act || tgt == modelPos) begin
            repeat (5) @(negedge clk);
            checkVal("nomove writes", wq.size() - base, 0);
            checkVal("nomove ready low", readyLow - rl0, 0);
            checkVal("nomove edgeHit cycles", edgeCnt - e0, act ? 1 : 0);
            checkVal("nomove posX", bus.posX, modelPos);
        end else begin
            n = 0;
            while (bus.ready !== 1'b1 && n < 1000) begin
                bus.left  = 1'($urandom);
                bus.right = 1'($urandom);
                @(negedge clk);
                n++;
            end
            bus.left  = 1'b0;
            bus.right = 1'b0;
            checkVal("move ready low cycles", readyLow - rl0, MOVE_LOW);
            checkMove("move", base, c0, 2, modelPos, tgt, 1'b1);
            checkVal("move posX", bus.posX, tgt);
            checkVal("move busy", busyBad - bb0, 0);
            checkVal("move edgeHit", edgeCnt - e0, 0);
            modelPos = tgt;
        end
    endtask

    initial begin
        int base, s, n, orderErr, k, r;
        wr_t w;
        reset     = 1'b0;
        bus.start = 1'b0;
        bus.left  = 1'b0;
        bus.right = 1'b0;
        for (int i = 0; i < 128; i++)
            rom[i] = 3'($urandom_range(0, 7));
        rom[0] = 3'(KEY);

        repeat (3) @(negedge clk);
        checkVal("rst xout", bus.xout, 0);
        checkVal("rst yout", bus.yout, 0);
        checkVal("rst colourOut", bus.colourOut, 0);
        checkVal("rst romAddr", bus.romAddr, 0);
        checkVal("rst drawEn", bus.drawEn, 0);
        checkVal("rst ready", bus.ready, 0);
        checkVal("rst busy", bus.busy, 0);
        checkVal("rst edgeHit", bus.edgeHit, 0);
        checkVal("rst posX", bus.posX, XS);

        reset = 1'b1;
        base = wq.size();
        repeat (10) @(negedge clk);
        checkVal("idle writes", wq.size() - base, 0);
        checkVal("idle busy", bus.busy, 0);
        checkVal("idle ready", bus.ready, 0);

        // Clear and home draw
        base = wq.size();
        s = cyc;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        while (bus.ready !== 1'b1 && n < 30000) begin
            @(negedge clk);
            n++;
        end
        checkVal("home ready cycle", cyc - s, 1 + (SW * SH + 1) + (NSPR + 1));
        orderErr = 0;
        for (int i = 0; i < SW * SH; i++) begin
            if (base + i >= wq.size()) begin
                orderErr++;
            end else begin
                w = wq[base + i];
                if (w.x != i % SW || w.y != i / SW || w.c != 0 || w.cyc - s != 2 + i)
                    orderErr++;
            end
        end
        checkVal("clear order errors", orderErr, 0);
        if (wq.size() >= base + SW * SH) begin
            w = wq[base + SW * SH - 1];
            checkVal("clear last pixel", pack(0, w.x, w.y, w.c), pack(0, SW - 1, SH - 1, 0));
        end else begin
            checkVal("clear last pixel count", wq.size() - base, SW * SH);
        end
        checkMove("home", base + SW * SH, s, 2 + SW * SH + 1, XS, XS, 1'b0);
        checkVal("home posX", bus.posX, XS);
        checkVal("home busy", bus.busy, 0);
        modelPos = XS;
        chkBusy = 1;

        doCmd(1'b1, 1'b0);
        checkVal("first left posX", modelPos, XS - STEP);
        doCmd(1'b1, 1'b1);
        doCmd(1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            r = $urandom_range(0, 3);
            doCmd(r[0], r[1]);
        end
        k = 0;
        while (modelPos > 0 && k < 40) begin
            doCmd(1'b1, 1'b0);
            k++;
        end
        doCmd(1'b1, 1'b0);
        k = 0;
        while (modelPos < POS_MAX && k < 40) begin
            r = $urandom_range(0, 99);
            if (r < 85) doCmd(1'b0, 1'b1);
            else doCmd(1'b1, 1'b1);
            k++;
        end
        doCmd(1'b0, 1'b1);
        checkVal("right clamp posX", bus.posX, POS_MAX);
        doCmd(1'b1, 1'b0);

        // Reset in the middle of an erase pass
        chkBusy = 0;
        bus.left = 1'b1;
        @(negedge clk);
        bus.left = 1'b0;
        repeat (30) @(negedge clk);
        reset = 1'b0;
        #1;
        checkVal("midrst drawEn", bus.drawEn, 0);
        checkVal("midrst xout", bus.xout, 0);
        checkVal("midrst yout", bus.yout, 0);
        checkVal("midrst colourOut", bus.colourOut, 0);
        checkVal("midrst romAddr", bus.romAddr, 0);
        checkVal("midrst busy", bus.busy, 0);
        checkVal("midrst ready", bus.ready, 0);
        checkVal("midrst posX", bus.posX, XS);
        @(negedge clk);
        reset = 1'b1;
        base = wq.size();
        repeat (20) @(negedge clk);
        checkVal("post-reset writes", wq.size() - base, 0);
        checkVal("post-reset busy", bus.busy, 0);
        checkVal("post-reset posX", bus.posX, XS);

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule

// File: doc/sprite_mover.md
# sprite_mover

Parametrised sprite controller for the game screen. It clears the frame buffer, then draws a ROM-backed sprite at a home position. Each left or right command moves the sprite with an erase, step and redraw sequence, followed by a hold-off before the next move. It sits between the key/control logic and the VGA adapter. The sprite size, step, screen size and move rate are all parameters, and the sprite ROM lives outside the block.

## Interface
- SCREEN_W, 160, screen width in pixels
- SCREEN_H, 120, screen height in pixels
- SPR_W, 11, sprite width
- SPR_H, 10, sprite height
- X_START, 73, home x (left column)
- Y_START, 105, fixed sprite y (top row)
- STEP, 5, pixels moved per command
- HOLD_CYCLES, 4, cooldown cycles after each move (≥1)
- COLOUR_W, 3, colour width
- ADDR_W, 7, sprite ROM address width (≥ clog2(SPR_W*SPR_H))
- TRANSPARENT, 3'd5, key colour (used only with the macro)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  level; begins clear and home draw from IDLE
- left  in  1  move-left request, sampled in READY
- right  in  1  move-right request, sampled in READY
- romData  in  COLOUR_W  sprite ROM output, 1-cycle read latency
- romAddr  out  ADDR_W  sprite ROM address, row-major
- xout  out  8  pixel x
- yout  out  7  pixel y
- colourOut  out  COLOUR_W  pixel colour
- drawEn  out  1  pixel write strobe
- ready  out  1  high in READY only
- busy  out  1  high in CLEAR, DRAW, ERASE, HOLD
- edgeHit  out  1  one-cycle pulse on a blocked move
- posX  out  8  current sprite left column

## Operation
- States: IDLE, CLEAR, DRAW, READY, ERASE, HOLD.
- IDLE: transitions to CLEAR when start=1.
- CLEAR:
  - writes every pixel black, row-major from (0,0) to (SCREEN_W-1, SCREEN_H-1).
  - then transitions to DRAW with posX=X_START.
- DRAW:
  - writes the SPR_W×SPR_H sprite at (posX, Y_START).
  - romAddr steps 0 … SPR_W*SPR_H-1.
  - transitions to HOLD after a move, or to READY after the home draw.
- READY: command decode.
  - left=1, right=0: target = posX-STEP, clamped to ≥0.
  - right=1, left=0: target = posX+STEP, clamped to ≤SCREEN_W-SPR_W.
  - both or neither: stay in READY.
  - target==posX: pulse edgeHit for one cycle, issue no pixel writes, stay in READY.
  - otherwise: latch target and go to ERASE.
- ERASE:
  - writes SPR_W×SPR_H black pixels at the old posX.
  - posX is updated to the target on the last erase cycle.
  - then goes to DRAW.
- HOLD: counts HOLD_CYCLES cycles, then goes to READY. Commands are ignored while in HOLD.
- Arithmetic: target is computed in 9-bit signed, then clamped. posX never leaves [0, SCREEN_W-SPR_W].
- Asynchronous reset in any state, including mid-pass:
  - state returns to IDLE.
  - outputs go to their reset values and any partial pass is abandoned.
  - posX returns to X_START.
- Reset values:
  - xout=0, yout=0, colourOut=0, romAddr=0.
  - drawEn=0, ready=0, busy=0, edgeHit=0.
  - posX=X_START.

## Timing
- Pixel pipeline:
  - Scan counters generate romAddr and (x,y) in cycle k.
  - xout, yout, colourOut and drawEn are registered and appear in cycle k+1, aligned with romData.
- A pass of N pixels takes N+1 cycles; drawEn is high for exactly N consecutive cycles, beginning one cycle after the state is entered.
- Per-pass cycle counts:
  - CLEAR: SCREEN_W*SCREEN_H+1.
  - DRAW and ERASE: SPR_W*SPR_H+1.
- Command latency: a command sampled in READY at cycle t produces its first ERASE write at t+2.
- Full move: ready is low for 2*(SPR_W*SPR_H+1)+HOLD_CYCLES cycles after the command cycle.
- In ERASE and CLEAR, colourOut=0 regardless of romData.
- After reset deasserts, the block takes no action until start is seen.

## Configuration
- SPRITE_TRANSPARENT_EN defined:
  - in DRAW, a pixel whose romData==TRANSPARENT has drawEn=0 for its slot; the pass length is unchanged.
  - CLEAR and ERASE are unaffected.
- SPRITE_TRANSPARENT_EN undefined: every sprite pixel is written, and the TRANSPARENT parameter is unused.

## Test plan
- Default parameters, reset, start=1 → exactly 19200 drawEn cycles with colour 0 ending at (159,119), then 110 DRAW writes spanning x 73..83, y 105..114, romAddr 0..109, then ready=1 with posX=73.
- READY with posX=73, left pulse → 110 black writes at x 73..83, then 110 sprite writes at x 68..78, then 4 HOLD cycles, ready=1, posX=68.
- posX=147, right → posX=149 (clamped), with a normal erase and redraw.
- posX=149, right → edgeHit high for exactly 1 cycle, zero drawEn cycles, ready stays 1.
- left and right both high in READY → no state change and no writes; a left asserted during HOLD is ignored.
- Reset asserted mid-ERASE → all outputs are at reset values immediately and posX=73. With SPRITE_TRANSPARENT_EN and ROM word 0 = 5, DRAW slot 0 has drawEn=0.
